// File: rtl/id_scoreboard_hazard.sv
// ID-stage hazard unit: per-register countdown scoreboard driving
// PC / IF-ID stalls and ID-EX bubbles, plus a saturating stall counter.
module id_scoreboard_hazard #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int ALU_LAT      = 0,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_EXTRA = 1,
    parameter int CNT_W        = 2,
    parameter int PERF_W       = 32
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                ID_Valid,
    input  logic [ADDR_W-1:0]   ID_rs,
    input  logic [ADDR_W-1:0]   ID_rt,
    input  logic                ID_UsesRs,
    input  logic                ID_UsesRt,
    input  logic                ID_IsBranch,
    input  logic                ID_WritesReg,
    input  logic                ID_IsLoad,
    input  logic [ADDR_W-1:0]   ID_rDest,
    input  logic                Flush_ID,
    output logic                Stall_PC,
    output logic                Stall_ID,
    output logic                Stall_ID_EX,
    output logic [NUM_REGS-1:0] Busy_Mask,
    output logic [PERF_W-1:0]   StallCount
);

    localparam logic [CNT_W-1:0] BE_C   = CNT_W'(BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] ALU_C  = CNT_W'(ALU_LAT + BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_LAT + BRANCH_EXTRA);

    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d [NUM_REGS];
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [CNT_W-1:0] cnt_rs, cnt_rt, new_cnt, dec;
    logic             haz_rs, haz_rt, hazard, issue, load_en;

    // Register 0 is never tracked, so its lookups fall through to zero.
    always_comb begin
        cnt_rs = '0;
        cnt_rt = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ID_rs == ADDR_W'(i)) cnt_rs = cnt_q[i];
            if (ID_rt == ADDR_W'(i)) cnt_rt = cnt_q[i];
        end
    end

    always_comb begin
        haz_rs = ID_UsesRs && (ID_rs != '0) &&
                 ((cnt_rs > BE_C) || (ID_IsBranch && (cnt_rs != '0)));
        haz_rt = ID_UsesRt && (ID_rt != '0) &&
                 ((cnt_rt > BE_C) || (ID_IsBranch && (cnt_rt != '0)));
        hazard  = ID_Valid && !Flush_ID && (haz_rs || haz_rt);
        issue   = ID_Valid && !Flush_ID && !hazard;
        load_en = issue && ID_WritesReg && (ID_rDest != '0);
        new_cnt = ID_IsLoad ? LOAD_C : ALU_C;
    end

    assign Stall_PC    = hazard;
    assign Stall_ID    = hazard;
    assign Stall_ID_EX = hazard;

    // WAW keeps the longer of the in-flight and the new latency.
    always_comb begin
        cnt_d[0] = '0;
        dec      = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            dec = (cnt_q[i] == '0) ? '0 : cnt_q[i] - CNT_W'(1);
            if (load_en && (ID_rDest == ADDR_W'(i)))
                cnt_d[i] = (dec > new_cnt) ? dec : new_cnt;
            else
                cnt_d[i] = dec;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        Busy_Mask = '0;
        for (int i = 1; i < NUM_REGS; i++)
            Busy_Mask[i] = (cnt_q[i] != '0);
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard_hazard.sv
// Bench for id_scoreboard_hazard: vector table with expectation queue,
// mid-cycle reset, and a small-counter build for saturation and WAW.
module tb_id_scoreboard_hazard;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       wr;
        logic       ld;
        logic [4:0] rd;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic        st;
        logic [31:0] busy;
        logic [31:0] sc;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic Clock = 0;
    logic Reset_n = 0;
    in_t  a = '0;
    in_t  b = '0;

    logic        st_pc, st_id, st_ex;
    logic [31:0] busy;
    logic [31:0] sc;
    logic        b_pc, b_id, b_ex;
    logic [31:0] b_busy;
    logic [1:0]  b_sc;

    int total = 0;
    int bad = 0;
    exp_t q[$];

    always #5 Clock = ~Clock;

    id_scoreboard_hazard dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .ID_Valid(a.valid), .ID_rs(a.rs), .ID_rt(a.rt),
        .ID_UsesRs(a.urs), .ID_UsesRt(a.urt),
        .ID_IsBranch(a.br), .ID_WritesReg(a.wr),
        .ID_IsLoad(a.ld), .ID_rDest(a.rd), .Flush_ID(a.fl),
        .Stall_PC(st_pc), .Stall_ID(st_id), .Stall_ID_EX(st_ex),
        .Busy_Mask(busy), .StallCount(sc)
    );

    id_scoreboard_hazard #(.LOAD_LAT(4), .CNT_W(3), .PERF_W(2)) dut2 (
        .Clock(Clock), .Reset_n(Reset_n),
        .ID_Valid(b.valid), .ID_rs(b.rs), .ID_rt(b.rt),
        .ID_UsesRs(b.urs), .ID_UsesRt(b.urt),
        .ID_IsBranch(b.br), .ID_WritesReg(b.wr),
        .ID_IsLoad(b.ld), .ID_rDest(b.rd), .Flush_ID(b.fl),
        .Stall_PC(b_pc), .Stall_ID(b_id), .Stall_ID_EX(b_ex),
        .Busy_Mask(b_busy), .StallCount(b_sc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs,
                               input logic urt, input logic br,
                               input logic wr, input logic ld,
                               input logic [4:0] rd, input logic fl);
        in_t r;
        r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.br = br; r.wr = wr; r.ld = ld; r.rd = rd; r.fl = fl;
        return r;
    endfunction

    function automatic exp_t ex(input logic st, input int bit_n,
                                input int scv);
        exp_t r;
        r.st = st;
        r.busy = (bit_n < 0) ? 32'h0 : (32'h1 << bit_n);
        r.sc = 32'(scv);
        return r;
    endfunction

    // Drive one cycle of stimulus, compare at mid-cycle, advance to next edge.
    task automatic step(input in_t v, input exp_t e, input int idx);
        exp_t g;
        a = v;
        q.push_back(e);
        @(negedge Clock);
        g = q.pop_front();
        chk($sformatf("v%0d stall_pc", idx), 32'(st_pc), 32'(g.st));
        chk($sformatf("v%0d stall_id", idx), 32'(st_id), 32'(g.st));
        chk($sformatf("v%0d stall_idex", idx), 32'(st_ex), 32'(g.st));
        chk($sformatf("v%0d busy", idx), busy, g.busy);
        chk($sformatf("v%0d stallcount", idx), sc, g.sc);
        @(posedge Clock);
        #1;
    endtask

    vec_t vt[28];
    in_t  idle;
    in_t  br11;
    int   n;

    initial begin
        idle = '0;
        //            v  rs  rt urs urt br wr ld rd fl
        vt[0]  = '{mk(1, 0, 0, 0, 0, 0, 1, 0, 8, 0),  ex(0, -1, 0)};
        vt[1]  = '{mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0),  ex(0, 8, 0)};
        vt[2]  = '{idle,                              ex(0, -1, 0)};
        vt[3]  = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 9, 0),  ex(0, -1, 0)};
        vt[4]  = '{mk(1, 9, 0, 1, 0, 0, 1, 0, 2, 0),  ex(1, 9, 0)};
        vt[5]  = '{mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0),  ex(0, 9, 1)};
        vt[6]  = '{mk(1, 0, 0, 0, 0, 0, 1, 0, 10, 0), ex(0, -1, 1)};
        vt[7]  = '{mk(1, 10, 0, 1, 0, 1, 0, 0, 0, 0), ex(1, 10, 1)};
        vt[8]  = '{mk(1, 10, 0, 1, 0, 1, 0, 0, 0, 0), ex(0, -1, 2)};
        vt[9]  = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 10, 0), ex(0, -1, 2)};
        vt[10] = '{mk(1, 10, 10, 1, 1, 1, 0, 0, 0, 0), ex(1, 10, 2)};
        vt[11] = '{mk(1, 10, 10, 1, 1, 1, 0, 0, 0, 0), ex(1, 10, 3)};
        vt[12] = '{mk(1, 10, 10, 1, 1, 1, 0, 0, 0, 0), ex(0, -1, 4)};
        vt[13] = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0),  ex(0, -1, 4)};
        vt[14] = '{mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0),  ex(0, -1, 4)};
        vt[15] = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 12, 0), ex(0, -1, 4)};
        vt[16] = '{mk(1, 12, 0, 1, 0, 0, 1, 0, 13, 1), ex(0, 12, 4)};
        vt[17] = '{idle,                              ex(0, 12, 4)};
        vt[18] = '{idle,                              ex(0, -1, 4)};
        vt[19] = '{mk(1, 14, 0, 1, 0, 0, 1, 1, 14, 0), ex(0, -1, 4)};
        vt[20] = '{mk(1, 14, 0, 1, 0, 0, 1, 0, 14, 0), ex(1, 14, 4)};
        vt[21] = '{mk(1, 14, 0, 1, 0, 0, 1, 0, 14, 0), ex(0, 14, 5)};
        vt[22] = '{idle,                              ex(0, 14, 5)};
        vt[23] = '{idle,                              ex(0, -1, 5)};
        vt[24] = '{mk(1, 0, 0, 0, 0, 0, 1, 1, 15, 0), ex(0, -1, 5)};
        vt[25] = '{mk(1, 15, 3, 0, 1, 0, 0, 0, 0, 0), ex(0, 15, 5)};
        vt[26] = '{mk(1, 0, 15, 0, 1, 1, 0, 0, 0, 0), ex(1, 15, 5)};
        vt[27] = '{idle,                              ex(0, -1, 6)};

        #1;
        chk("reset stall", 32'({st_pc, st_id, st_ex}), 32'h0);
        chk("reset busy", busy, 32'h0);
        chk("reset stallcount", sc, 32'h0);

        @(posedge Clock);
        #1 Reset_n = 1;

        for (int i = 0; i < 28; i++) step(vt[i].i, vt[i].e, i);

        // Load $11, then pull reset between edges while cnt[11] = 2.
        step(mk(1, 0, 0, 0, 0, 0, 1, 1, 11, 0), ex(0, -1, 6), 28);
        br11 = mk(1, 11, 0, 1, 0, 1, 0, 0, 0, 0);
        a = br11;
        #1;
        chk("pre-reset busy", busy, 32'h1 << 11);
        chk("pre-reset stall", 32'(st_pc), 32'h1);
        #1 Reset_n = 0;
        #1;
        chk("async reset busy", busy, 32'h0);
        chk("async reset stall", 32'({st_pc, st_id, st_ex}), 32'h0);
        chk("async reset stallcount", sc, 32'h0);
        @(posedge Clock);
        #1;
        chk("held reset stall", 32'({st_pc, st_id, st_ex}), 32'h0);
        Reset_n = 1;
        step(br11, ex(0, -1, 0), 29);
        a = idle;

        // Small-counter build: 5-cycle stall saturates a 2-bit counter.
        b = mk(1, 0, 0, 0, 0, 0, 1, 1, 5, 0);
        @(posedge Clock);
        #1 b = mk(1, 5, 0, 1, 0, 1, 0, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (!b_pc) break;
            n++;
            @(posedge Clock);
            #1;
        end
        chk("p2 stall cycles", 32'(n), 32'd5);
        chk("p2 stallcount sat", 32'(b_sc), 32'd3);
        chk("p2 stall_id", 32'(b_id), 32'(b_ex));

        // WAW: ALU write behind a long load keeps the longer count.
        @(posedge Clock);
        #1 b = mk(1, 0, 0, 0, 0, 0, 1, 1, 6, 0);
        @(posedge Clock);
        #1 b = mk(1, 0, 0, 0, 0, 0, 1, 0, 6, 0);
        @(posedge Clock);
        #1 b = mk(1, 6, 0, 1, 0, 1, 0, 0, 0, 0);
        @(negedge Clock);
        chk("p2 waw busy", b_busy, 32'h1 << 6);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!b_pc) break;
            n++;
            @(posedge Clock);
            #1;
            @(negedge Clock);
        end
        chk("p2 waw stall cycles", 32'(n), 32'd4);
        @(posedge Clock);
        #1 b = idle;
        @(posedge Clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
